// File: rtl/ram_bist_ctrl.sv
// BIST controller for a single-port synchronous RAM: write PATTERN up, read/compare up,
// write ~PATTERN down, read/compare down; reports pass and the first failing address/data.
module ram_bist_ctrl #(
  parameter int              AW      = 3,
  parameter int              DW      = 8,
  parameter logic [DW-1:0]   PATTERN = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_data,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [2:0] {IDLE, WR_P, RD_P, WR_N, RD_N, DONE} state_t;

  localparam logic [AW-1:0] LAST = '1;

  state_t        state;
  logic          drain;
  logic          cmp_valid;
  logic [AW-1:0] cmp_addr;
  logic [DW-1:0] cmp_exp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      drain     <= 1'b0;
      cmp_valid <= 1'b0;
      cmp_addr  <= '0;
      cmp_exp   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= WR_P;
            busy     <= 1'b1;
            pass     <= 1'b1;
            ram_we   <= 1'b1;
            ram_addr <= '0;
            ram_din  <= PATTERN;
          end
        end
        WR_P: begin
          if (ram_addr == LAST) begin
            state    <= RD_P;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            drain    <= 1'b0;
          end else begin
            ram_addr <= ram_addr + 1'b1;
          end
        end
        RD_P, RD_N: begin
          // The compare of the previous read takes priority; a mismatch aborts straight to DONE.
          if (cmp_valid && (ram_dout != cmp_exp)) begin
            fail_addr <= cmp_addr;
            fail_data <= ram_dout;
            pass      <= 1'b0;
            cmp_valid <= 1'b0;
            drain     <= 1'b0;
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (drain) begin
            cmp_valid <= 1'b0;
            drain     <= 1'b0;
            if (state == RD_P) begin
              state    <= WR_N;
              ram_we   <= 1'b1;
              ram_addr <= LAST;
              ram_din  <= ~PATTERN;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            cmp_valid <= 1'b1;
            cmp_addr  <= ram_addr;
            cmp_exp   <= (state == RD_P) ? PATTERN : ~PATTERN;
            if (state == RD_P) begin
              if (ram_addr == LAST) drain <= 1'b1;
              else                  ram_addr <= ram_addr + 1'b1;
            end else begin
              if (ram_addr == '0) drain <= 1'b1;
              else                ram_addr <= ram_addr - 1'b1;
            end
          end
        end
        WR_N: begin
          if (ram_addr == '0) begin
            state    <= RD_N;
            ram_we   <= 1'b0;
            ram_addr <= LAST;
            drain    <= 1'b0;
          end else begin
            ram_addr <= ram_addr - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural RAM with injectable faults plus an operation-list
// reference model that predicts every RAM access, the run length and the pass/fail result.
module tb_ram_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, pass;
  logic [2:0] fail_addr;
  logic [7:0] fail_data;
  logic       ram_we;
  logic [2:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout = 8'h00;

  ram_bist_ctrl #(.AW(3), .DW(8), .PATTERN(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Fault model: kind 0 none, 1 stuck bit on read at flt_addr, 2 writes to 6 land in 7.
  int         flt_kind = 0;
  logic [2:0] flt_addr = 3'd0;
  int         flt_bit  = 0;
  logic       flt_val  = 1'b0;
  logic       clr      = 1'b0;

  function automatic logic [2:0] wmap(input logic [2:0] a);
    return (flt_kind == 2 && a == 3'd6) ? 3'd7 : a;
  endfunction

  function automatic logic [7:0] rmap(input logic [2:0] a, input logic [7:0] v);
    logic [7:0] m;
    m = 8'h01 << flt_bit;
    if (flt_kind == 1 && a == flt_addr) return flt_val ? (v | m) : (v & ~m);
    return v;
  endfunction

  logic [7:0] mem [8];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
    end else if (ram_we) begin
      mem[wmap(ram_addr)] <= ram_din;
    end else begin
      ram_dout <= rmap(ram_addr, mem[ram_addr]);
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [7:0] refm [8];
  int         q_we [40];
  int         q_addr [40];
  int         q_din [40];
  int         q_rd [40];
  int         q_exp [40];
  int         nops;
  int         e_busy;
  logic       e_pass;
  logic [2:0] e_fa = 3'd0;
  logic [7:0] e_fd = 8'h00;

  task automatic add_op(input int we, input int a, input int din, input int rd, input int ex);
    q_we[nops] = we; q_addr[nops] = a; q_din[nops] = din; q_rd[nops] = rd; q_exp[nops] = ex;
    nops++;
  endtask

  // Build the access list from the test rules, then replay it on refm to find the first miscompare.
  task automatic build;
    logic [7:0] v;
    nops = 0;
    for (int a = 0; a < 8; a++)  add_op(1, a, 8'hA5, 0, 0);
    for (int a = 0; a < 8; a++)  add_op(0, a, 0, 1, 8'hA5);
    add_op(0, 7, 0, 0, 0);
    for (int a = 7; a >= 0; a--) add_op(1, a, 8'h5A, 0, 0);
    for (int a = 7; a >= 0; a--) add_op(0, a, 0, 1, 8'h5A);
    add_op(0, 0, 0, 0, 0);
    e_busy = nops;
    e_pass = 1'b1;
    for (int i = 0; i < nops; i++) begin
      if (q_we[i] != 0) begin
        refm[wmap(3'(q_addr[i]))] = 8'(q_din[i]);
      end else if (q_rd[i] != 0) begin
        v = rmap(3'(q_addr[i]), refm[q_addr[i]]);
        if (v != 8'(q_exp[i])) begin
          e_busy = i + 2;
          e_pass = 1'b0;
          e_fa   = 3'(q_addr[i]);
          e_fd   = v;
          break;
        end
      end
    end
  endtask

  task automatic do_run(input bit prestarted, input bit pulse_wrn, input int abort_at,
                        input bit hold_end);
    build();
    if (!prestarted) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < e_busy; c++) begin
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      chk("pass_run", pass, 1);
      chk("ram_we", ram_we, q_we[c]);
      chk("ram_addr", ram_addr, q_addr[c]);
      if (q_we[c] != 0) chk("ram_din", ram_din, q_din[c]);
      start = pulse_wrn && (c == 20);
      if (abort_at != 0 && c == abort_at - 1) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e_fa = 3'd0; e_fd = 8'h00; e_pass = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_pass", pass, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_fa", fail_addr, 0);
        chk("rst_fd", fail_data, 0);
        return;
      end
      @(negedge clk);
    end
    chk("end_busy", busy, 0);
    chk("end_done", done, 1);
    chk("end_we", ram_we, 0);
    chk("end_pass", pass, e_pass);
    chk("end_fa", fail_addr, e_fa);
    chk("end_fd", fail_data, e_fd);
    if (hold_end) start = 1'b1;
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_we", ram_we, 0);
  endtask

  initial begin
    int gap;
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) refm[i] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    chk("reset_fa", fail_addr, 0);
    chk("reset_fd", fail_data, 0);
    chk("reset_we", ram_we, 0);
    chk("reset_addr", ram_addr, 0);
    chk("reset_din", ram_din, 0);
    rst = 1'b0;

    // Fault-free run
    flt_kind = 0;
    do_run(0, 0, 0, 0);
    chk("clean_len", e_busy, 34);

    // Bit 3 stuck-at-0 at address 5
    flt_kind = 1; flt_addr = 3'd5; flt_bit = 3; flt_val = 1'b0;
    do_run(0, 0, 0, 0);
    chk("stuck_fa", fail_addr, 5);
    chk("stuck_fd", fail_data, 8'h52);
    chk("stuck_pass", pass, 0);

    // Address alias 6 -> 7 with zeroed memory
    flt_kind = 2;
    clr = 1'b1;
    for (int i = 0; i < 8; i++) refm[i] = 8'h00;
    @(negedge clk);
    clr = 1'b0;
    do_run(0, 0, 0, 0);
    chk("alias_fa", fail_addr, 6);
    chk("alias_fd", fail_data, 8'h00);

    // Back-to-back pass keeps earlier failure capture
    flt_kind = 0;
    do_run(0, 0, 0, 0);
    chk("b2b_pass", pass, 1);
    chk("b2b_fa", fail_addr, 6);
    chk("b2b_fd", fail_data, 8'h00);

    // Reset in cycle 12, then a fresh full run
    do_run(0, 0, 12, 0);
    do_run(0, 0, 0, 0);

    // Start pulsed during WR_N and held through DONE launches an immediate second run
    do_run(0, 1, 0, 1);
    do_run(1, 0, 0, 0);

    // Randomized stuck-at faults and idle gaps
    for (int r = 0; r < 6; r++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) @(negedge clk);
      flt_kind = $urandom_range(0, 1);
      flt_addr = 3'($urandom_range(0, 7));
      flt_bit  = $urandom_range(0, 7);
      flt_val  = 1'($urandom_range(0, 1));
      do_run(0, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
